// File: rtl/result_drain.sv
// result_drain: walks a finished result tile, reads the buffer and streams elements out over valid/ready.
// Ports: clk, rst (async, active-high); start -> busy/done; rd_en/rd_addr/rd_data to the result buffer
// (1-cycle read latency); out_valid/out_ready/out_data/out_col/out_row/out_last stream.
// Define RESULT_DRAIN_COLMAJOR_EN for column-major traversal (row innermost); default is row-major.
module result_drain #(
  parameter int WIDTH = 32,
  parameter int HEIGHT = 32,
  parameter int DATA_W = 32,
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1,
  localparam int RW = HEIGHT > 1 ? $clog2(HEIGHT) : 1,
  localparam int AW = WIDTH * HEIGHT > 1 ? $clog2(WIDTH * HEIGHT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     out_col,
  output logic [RW-1:0]     out_row,
  output logic              out_last
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] col, p_col;
  logic [RW-1:0] row, p_row;
  logic issuing, inflight, p_last, pop, col_end, row_end, last_issue;
  logic [DATA_W-1:0] f_data [2];
  logic [CW-1:0] f_col [2];
  logic [RW-1:0] f_row [2];
  logic f_last [2];
  logic wr_ptr, rd_ptr;
  logic [1:0] count;
  logic [2:0] occ;
  assign col_end = col == CW'(WIDTH - 1);
  assign row_end = row == RW'(HEIGHT - 1);
  assign last_issue = col_end && row_end;
  assign out_valid = count != 2'd0;
  assign pop = out_valid && out_ready;
  // Slots already claimed: buffered entries plus the read whose data lands next edge, minus the one leaving now.
  assign occ = 3'(count) + 3'(inflight) - 3'(pop);
  assign rd_en = state == RUN && issuing && occ < 3'd2;
  assign rd_addr = AW'(row) * AW'(WIDTH) + AW'(col);
  assign out_data = f_data[rd_ptr];
  assign out_col = f_col[rd_ptr];
  assign out_row = f_row[rd_ptr];
  assign out_last = out_valid && f_last[rd_ptr];
  always_comb begin
    state_n = state;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: state_n = start ? RUN : IDLE;
      RUN: begin
        busy = 1'b1;
        state_n = pop && out_last ? DONE : RUN;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      issuing <= 1'b0;
      inflight <= 1'b0;
      p_col <= '0;
      p_row <= '0;
      p_last <= 1'b0;
    end else begin
      state <= state_n;
      inflight <= rd_en;
      if (rd_en) begin
        p_col <= col;
        p_row <= row;
        p_last <= last_issue;
      end
      if (state == IDLE && start) begin
        col <= '0;
        row <= '0;
        issuing <= 1'b1;
      end else if (rd_en) begin
        issuing <= !last_issue;
`ifdef RESULT_DRAIN_COLMAJOR_EN
        row <= row_end ? '0 : row + 1'b1;
        if (row_end) col <= col_end ? '0 : col + 1'b1;
`else
        col <= col_end ? '0 : col + 1'b1;
        if (col_end) row <= row_end ? '0 : row + 1'b1;
`endif
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        f_data[i] <= '0;
        f_col[i] <= '0;
        f_row[i] <= '0;
        f_last[i] <= 1'b0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (inflight) begin
        f_data[wr_ptr] <= rd_data;
        f_col[wr_ptr] <= p_col;
        f_row[wr_ptr] <= p_row;
        f_last[wr_ptr] <= p_last;
        wr_ptr <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      count <= count + 2'(inflight) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: directed checks of result_drain (4x3 tile plus a 1x1 tile instance).
module tb_result_drain;
  localparam int W = 4, H = 3, N = 12;
  logic clk = 0, rst = 1, start = 0, out_ready = 0;
  logic busy, done, rd_en, out_valid, out_last;
  logic [3:0] rd_addr;
  logic [1:0] out_col, out_row;
  logic [31:0] rd_data, out_data;
  logic start_s = 0, ready_s = 1;
  logic busy_s, done_s, rd_en_s, valid_s, last_s;
  logic [0:0] addr_s, col_s, row_s;
  logic [31:0] rdata_s, data_s;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  result_drain #(.WIDTH(W), .HEIGHT(H), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_col(out_col), .out_row(out_row), .out_last(out_last));
  result_drain #(.WIDTH(1), .HEIGHT(1), .DATA_W(32)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s), .rd_en(rd_en_s),
    .rd_addr(addr_s), .rd_data(rdata_s), .out_valid(valid_s), .out_ready(ready_s),
    .out_data(data_s), .out_col(col_s), .out_row(row_s), .out_last(last_s));
  always @(posedge clk) rd_data <= rd_en ? 32'h1000 + 32'(rd_addr) * 7 : 32'hDEAD_BEEF;
  always @(posedge clk) rdata_s <= rd_en_s ? 32'h5A5A_0001 : 32'hDEAD_BEEF;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int exp_addr(input int k);
`ifdef RESULT_DRAIN_COLMAJOR_EN
    return (k % H) * W + k / H;
`else
    return k;
`endif
  endfunction
  task automatic drain(input int mode, input bit poke);
    int k = 0, reads = 0, acc = 0, dcnt = 0, last_hs = -1, done_cyc = -1, first = -1;
    bit stalled = 0, fin = 0, pop;
    logic [36:0] snap = '0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(negedge clk);
      start = cyc == 0 || (poke && (cyc == 6 || (last_hs >= 0 && cyc == last_hs + 1)));
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : cyc > 20;
      #1;
      pop = out_valid && out_ready;
      if (cyc == 1) begin
        check("rd_en_c1", rd_en, 1);
        check("rd_addr_c1", rd_addr, 0);
        check("busy_c1", busy, 1);
      end
      if (stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_out", {out_data, out_col, out_row, out_last}, snap);
      end
      if (out_valid && first < 0) begin
        first = cyc;
        check("first_valid_cyc", cyc, 3);
      end
      if (rd_en) begin
        check("credit", (reads - acc - int'(pop)) < 2, 1);
        check("rd_addr", rd_addr, exp_addr(reads));
        reads++;
      end
      if (pop) begin
        check("out_data", out_data, 32'h1000 + exp_addr(k) * 7);
        check("out_col", out_col, exp_addr(k) % W);
        check("out_row", out_row, exp_addr(k) / W);
        check("out_last", out_last, k == N - 1);
        k++;
        acc++;
        if (k == N) begin
          last_hs = cyc;
          if (mode == 0) check("last_hs_cyc", cyc, N + 2);
        end
      end
      if (done) begin
        dcnt++;
        check("done_cyc", cyc, last_hs + 1);
        done_cyc = cyc;
      end
      if (mode == 2 && cyc == 20) check("reads_stalled", reads, 2);
      if (done_cyc >= 0 && cyc == done_cyc + 3) begin
        check("idle_busy", busy, 0);
        fin = 1;
      end
      stalled = out_valid && !out_ready;
      snap = {out_data, out_col, out_row, out_last};
    end
    if (!fin) check("timeout", 0, 1);
    check("elements", k, N);
    check("done_count", dcnt, 1);
    check("reads", reads, N);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_col"}, out_col, 0);
    check({tag, "_row"}, out_row, 0);
    check({tag, "_addr"}, rd_addr, 0);
  endtask
  initial begin
    int hs;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 0;
    drain(0, 0);
    drain(1, 0);
    drain(2, 0);
    drain(0, 1);
    @(negedge clk);
    start = 1;
    out_ready = 1;
    hs = 0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      start = 0;
      #1;
      if (out_valid && out_ready) hs++;
    end
    check("hs_before_rst", hs, 5);
    #2 rst = 1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 0;
    drain(0, 0);
    for (int cyc = 0; cyc <= 5; cyc++) begin
      @(negedge clk);
      start_s = cyc == 0;
      #1;
      if (cyc == 1) check("s_rd_en", rd_en_s, 1);
      if (cyc == 3) begin
        check("s_valid", valid_s, 1);
        check("s_last", last_s, 1);
        check("s_data", data_s, 32'h5A5A_0001);
        check("s_pos", {col_s, row_s}, 0);
      end
      if (cyc == 4) begin
        check("s_done", done_s, 1);
        check("s_valid_after", valid_s, 0);
      end
      if (cyc == 5) check("s_idle", busy_s, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
